// File: rtl/mul16_seq_if.sv
// rtl/mul16_seq_if.sv - start/busy/done handshake bundle for the sequential multiplier
//
// Purpose: groups the operand, request and result signals of mul16_seq.
// Signals:
//   start  request, sampled on the rising clock edge
//   a      multiplicand, captured when a start is accepted
//   b      multiplier, captured when a start is accepted
//   out    low WIDTH bits of the product, held between completions
//   busy   high while a multiplication is in progress
//   done   one-cycle pulse when out has just been updated
// Modports: master drives the request side, slave is the multiplier.
interface mul16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  out, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, busy, done
  );
endinterface

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - fixed-latency shift-and-add multiplier co-unit for the Hack datapath
//
// Purpose: multiplies two WIDTH-bit operands in exactly WIDTH clock cycles and
// returns the product modulo 2^WIDTH (identical for signed and unsigned).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset; discards any operation in flight
//   bus    mul16_seq_if slave: start/a/b in, out/busy/done out
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] acc_next;

  // Partial-product step; carry out of the top bit is intentionally dropped.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      out_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
          end
        end

        RUN: begin
          // start is ignored here; operands live only in mcand/mplier.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            out_r  <= acc_next;
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end

        DONE: begin
          done_r <= 1'b0;
          // Back-to-back request goes straight to RUN with no IDLE gap.
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - randomized self-checking bench for mul16_seq
module tb_mul16_seq;

  logic clk;
  logic reset;

  mul16_seq_if #(.WIDTH(16)) bus ();

  mul16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted request completes 16 edges later with
  // (a*b) mod 2^16; requests are accepted only when nothing is in flight.
  int unsigned edge_n   = 0;
  bit          m_active = 0;
  int unsigned m_end    = 0;
  logic [15:0] m_res    = '0;
  logic [15:0] exp_out  = '0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  logic [31:0] prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      exp_out  = '0;
      exp_busy = 0;
      exp_done = 0;
    end else begin
      edge_n   = edge_n + 1;
      exp_done = 0;
      if (m_active) begin
        if (edge_n == m_end) begin
          m_active = 0;
          exp_out  = m_res;
          exp_done = 1;
        end
      end else if (bus.start) begin
        prod     = 32'(bus.a) * 32'(bus.b);
        m_res    = prod[15:0];
        m_end    = edge_n + 16;
        m_active = 1;
      end
      exp_busy = m_active;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    chk("done", {31'd0, bus.done}, {31'd0, exp_done});
    chk("out",  {16'd0, bus.out},  {16'd0, exp_out});
    if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
  end

  // Leaves the caller 2 time units after the accepting edge E0.
  task automatic drive_start(input logic [15:0] av, input logic [15:0] bv);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  int n;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_out", {16'd0, bus.out}, 32'h0);
    chk("reset_busy", {31'd0, bus.busy}, 32'h0);

    // 3*5: busy exactly 16 cycles, then result held.
    drive_start(16'd3, 16'd5);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) n++;
    end
    chk("busy_cycles", n, 16);
    chk("out_3x5", {16'd0, bus.out}, 32'h000F);
    repeat (3) @(negedge clk);
    chk("hold_3x5", {16'd0, bus.out}, 32'h000F);
    chk("idle_busy", {31'd0, bus.busy}, 32'h0);

    drive_start(16'hFFFD, 16'h0007);
    wait_done("neg", 40);
    chk("out_neg", {16'd0, bus.out}, 32'hFFEB);
    drive_start(16'hFFFF, 16'hFFFF);
    wait_done("ones", 40);
    chk("out_ones", {16'd0, bus.out}, 32'h0001);
    drive_start(16'h0100, 16'h0100);
    wait_done("ovf", 40);
    chk("out_ovf", {16'd0, bus.out}, 32'h0000);

    // Start while busy is ignored.
    drive_start(16'd2, 16'd2);
    repeat (4) @(posedge clk);
    #2 bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
    @(posedge clk); #2 bus.start = 1'b0;
    wait_done("ignore", 40);
    chk("out_ignore", {16'd0, bus.out}, 32'h0004);
    count_done(30, n);
    chk("no_second_done", n, 0);

    // Reset in the middle of an operation.
    drive_start(16'd7, 16'd7);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_out", {16'd0, bus.out}, 32'h0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'h0);
    chk("rst_mid_done", {31'd0, bus.done}, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    count_done(30, n);
    chk("rst_no_done", n, 0);

    // Back-to-back: start held during the DONE cycle.
    drive_start(16'd4, 16'd6);
    repeat (16) @(posedge clk);
    #2 bus.start = 1'b1; bus.a = 16'd10; bus.b = 16'd10;
    @(negedge clk);
    chk("b2b_done1", {31'd0, bus.done}, 32'h1);
    chk("b2b_out1", {16'd0, bus.out}, 32'h0018);
    @(posedge clk); #2 bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, bus.busy}, 32'h1);
    wait_done("b2b", 40);
    chk("b2b_out2", {16'd0, bus.out}, 32'h0064);

    // Operands may change after acceptance.
    drive_start(16'd5, 16'd3);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    wait_done("opchg", 40);
    chk("out_opchg", {16'd0, bus.out}, 32'h000F);

    // Random traffic, including stray starts while busy and back-to-back.
    for (int k = 0; k < 40; k++) begin
      drive_start(16'($urandom), 16'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 22)); j++) begin
        @(posedge clk); #2;
        bus.start = ($urandom_range(0, 3) == 0);
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
      end
      @(posedge clk); #2 bus.start = 1'b0;
    end
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
